// File: rtl/jtframe_ddram_arb_pkg.sv
// Shared types and helpers for the two-requester DDR3 burst arbiter.
package jtframe_ddram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } arb_state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    // A burst count of zero still moves one beat
    function automatic logic [7:0] len0(input logic [7:0] burstcnt);
        return (burstcnt == 8'd0) ? 8'd1 : burstcnt;
    endfunction

endpackage

// File: rtl/jtframe_ddram_arb.sv
// Whole-burst arbiter between two Avalon-style requesters and the MiSTer ddram_* port.
module jtframe_ddram_arb
    import jtframe_ddram_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int AW         = 29
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_burstcnt,
    input  logic          a_rd,
    input  logic          a_we,
    input  logic [63:0]   a_din,
    input  logic [7:0]    a_be,
    output logic          a_busy,
    output logic          a_dout_ready,

    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_burstcnt,
    input  logic          b_rd,
    input  logic          b_we,
    input  logic [63:0]   b_din,
    input  logic [7:0]    b_be,
    output logic          b_busy,
    output logic          b_dout_ready,

    output logic [63:0]   dout,

    input  logic          ddram_busy,
    output logic [7:0]    ddram_burstcnt,
    output logic [AW-1:0] ddram_addr,
    output logic          ddram_rd,
    output logic          ddram_we,
    output logic [63:0]   ddram_din,
    output logic [7:0]    ddram_be,
    input  logic [63:0]   ddram_dout,
    input  logic          ddram_dout_ready
);

    arb_state_t  state;
    logic        gnt;
    logic        last;
    logic [7:0]  len;
    logic [7:0]  cnt;

    logic        req_a, req_b;
    logic        pick;
    logic        pick_rd;
    logic [7:0]  pick_bc;
    logic        g_rd, g_we;
    logic        last_beat;

    assign req_a = a_rd | a_we;
    assign req_b = b_rd | b_we;

    // On a tie, round-robin favours whoever did not win last time
    always_comb begin
        pick = GNT_A;
        if (req_a && req_b)
            pick = (FIXED_PRIO != 0 || last == GNT_B) ? GNT_A : GNT_B;
        else if (req_b)
            pick = GNT_B;
    end

    assign pick_rd   = (pick == GNT_A) ? a_rd       : b_rd;
    assign pick_bc   = (pick == GNT_A) ? a_burstcnt : b_burstcnt;
    assign g_rd      = (gnt == GNT_A)  ? a_rd       : b_rd;
    assign g_we      = (gnt == GNT_A)  ? a_we       : b_we;
    assign last_beat = (cnt == len - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= GNT_A;
            last  <= GNT_B;
            len   <= 8'd1;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        gnt   <= pick;
                        last  <= pick;
                        len   <= len0(pick_bc);
                        cnt   <= 8'd0;
                        state <= pick_rd ? RD_CMD : WR;
                    end
                end
                RD_CMD: begin
                    if (!g_rd)
                        state <= IDLE;
                    else if (!ddram_busy)
                        state <= RD_DATA;
                end
                RD_DATA: begin
                    if (ddram_dout_ready) begin
                        cnt <= cnt + 8'd1;
                        if (last_beat) state <= IDLE;
                    end
                end
                WR: begin
                    // Gaps after the first beat keep the grant; a drop before it abandons
                    if (g_we && !ddram_busy) begin
                        cnt <= cnt + 8'd1;
                        if (last_beat) state <= IDLE;
                    end else if (!g_we && cnt == 8'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic fwd_busy;
    assign fwd_busy = (state == RD_CMD || state == WR) ? ddram_busy : 1'b1;

    assign a_busy         = (gnt == GNT_A) ? fwd_busy : 1'b1;
    assign b_busy         = (gnt == GNT_B) ? fwd_busy : 1'b1;
    assign a_dout_ready   = (state == RD_DATA) && (gnt == GNT_A) && ddram_dout_ready;
    assign b_dout_ready   = (state == RD_DATA) && (gnt == GNT_B) && ddram_dout_ready;
    assign dout           = ddram_dout;

    assign ddram_rd       = (state == RD_CMD) && g_rd;
    assign ddram_we       = (state == WR) && g_we;
    assign ddram_burstcnt = len;
    assign ddram_addr     = (gnt == GNT_A) ? a_addr : b_addr;
    assign ddram_din      = (gnt == GNT_A) ? a_din  : b_din;
    assign ddram_be       = (gnt == GNT_A) ? a_be   : b_be;

endmodule

// File: tb/tb_jtframe_ddram_arb.sv
// Directed bench for jtframe_ddram_arb: cycle vector table plus reset and fixed-priority sequences.
module tb_jtframe_ddram_arb;

    localparam int AW = 29;
    localparam logic [AW-1:0] ADDR_A = 29'h100;
    localparam logic [AW-1:0] ADDR_B = 29'h200;
    localparam logic [63:0]   DIN_A  = 64'hAAAA_0000_1111_2222;
    localparam logic [63:0]   DIN_B  = 64'hBBBB_3333_4444_5555;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a_addr = ADDR_A, b_addr = ADDR_B;
    logic [7:0]    a_burstcnt = '0, b_burstcnt = '0;
    logic          a_rd = 0, a_we = 0, b_rd = 0, b_we = 0;
    logic [63:0]   a_din = DIN_A, b_din = DIN_B;
    logic [7:0]    a_be = 8'h0F, b_be = 8'hF0;
    logic          a_busy, a_dout_ready, b_busy, b_dout_ready;
    logic [63:0]   dout;
    logic          ddram_busy = 0;
    logic [7:0]    ddram_burstcnt;
    logic [AW-1:0] ddram_addr;
    logic          ddram_rd, ddram_we;
    logic [63:0]   ddram_din;
    logic [7:0]    ddram_be;
    logic [63:0]   ddram_dout = '0;
    logic          ddram_dout_ready = 0;

    // Fixed-priority instance with its own control signals
    logic          f_a_rd = 0, f_b_rd = 0, f_busy = 0, f_dr = 0;
    logic          f_a_busy, f_a_dr, f_b_busy, f_b_dr;
    logic [63:0]   f_dout;
    logic [7:0]    f_burstcnt;
    logic [AW-1:0] f_addr;
    logic          f_rd, f_we;
    logic [63:0]   f_din;
    logic [7:0]    f_be;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jtframe_ddram_arb #(.FIXED_PRIO(0), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a_addr), .a_burstcnt(a_burstcnt), .a_rd(a_rd), .a_we(a_we),
        .a_din(a_din), .a_be(a_be), .a_busy(a_busy), .a_dout_ready(a_dout_ready),
        .b_addr(b_addr), .b_burstcnt(b_burstcnt), .b_rd(b_rd), .b_we(b_we),
        .b_din(b_din), .b_be(b_be), .b_busy(b_busy), .b_dout_ready(b_dout_ready),
        .dout(dout), .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt),
        .ddram_addr(ddram_addr), .ddram_rd(ddram_rd), .ddram_we(ddram_we),
        .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(ddram_dout),
        .ddram_dout_ready(ddram_dout_ready)
    );

    jtframe_ddram_arb #(.FIXED_PRIO(1), .AW(AW)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a_addr), .a_burstcnt(8'd2), .a_rd(f_a_rd), .a_we(1'b0),
        .a_din(a_din), .a_be(a_be), .a_busy(f_a_busy), .a_dout_ready(f_a_dr),
        .b_addr(b_addr), .b_burstcnt(8'd2), .b_rd(f_b_rd), .b_we(1'b0),
        .b_din(b_din), .b_be(b_be), .b_busy(f_b_busy), .b_dout_ready(f_b_dr),
        .dout(f_dout), .ddram_busy(f_busy), .ddram_burstcnt(f_burstcnt),
        .ddram_addr(f_addr), .ddram_rd(f_rd), .ddram_we(f_we),
        .ddram_din(f_din), .ddram_be(f_be), .ddram_dout(ddram_dout),
        .ddram_dout_ready(f_dr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]    in;   // a_rd a_we b_rd b_we ddram_busy ddram_dout_ready
        logic [7:0]    a_bc;
        logic [7:0]    b_bc;
        logic [5:0]    ex;   // a_busy b_busy a_dout_ready b_dout_ready ddram_rd ddram_we
        logic [7:0]    e_bc; // 0 = not checked
        logic [AW-1:0] e_addr; // 0 = not checked
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [5:0] in, input logic [7:0] abc, input logic [7:0] bbc,
                               input logic [5:0] ex, input logic [7:0] ebc, input logic [AW-1:0] ea);
        vec_t r;
        r.in = in; r.a_bc = abc; r.b_bc = bbc; r.ex = ex; r.e_bc = ebc; r.e_addr = ea;
        return r;
    endfunction

    task automatic check_outs(input string tag, input logic [5:0] ex);
        chk({tag, ".a_busy"},       {63'd0, a_busy},       {63'd0, ex[5]});
        chk({tag, ".b_busy"},       {63'd0, b_busy},       {63'd0, ex[4]});
        chk({tag, ".a_dout_ready"}, {63'd0, a_dout_ready}, {63'd0, ex[3]});
        chk({tag, ".b_dout_ready"}, {63'd0, b_dout_ready}, {63'd0, ex[2]});
        chk({tag, ".ddram_rd"},     {63'd0, ddram_rd},     {63'd0, ex[1]});
        chk({tag, ".ddram_we"},     {63'd0, ddram_we},     {63'd0, ex[0]});
    endtask

    initial begin
        // Single read of 4 beats by A
        tbl.push_back(v(6'b000000, 0, 0, 6'b110000, 0, 0));
        tbl.push_back(v(6'b100000, 4, 0, 6'b110000, 0, 0));
        tbl.push_back(v(6'b100000, 4, 0, 6'b010010, 4, ADDR_A));
        tbl.push_back(v(6'b000001, 4, 0, 6'b111000, 0, 0));
        tbl.push_back(v(6'b000000, 4, 0, 6'b110000, 0, 0));
        tbl.push_back(v(6'b000001, 4, 0, 6'b111000, 0, 0));
        tbl.push_back(v(6'b000001, 4, 0, 6'b111000, 0, 0));
        tbl.push_back(v(6'b000001, 4, 0, 6'b111000, 0, 0));
        tbl.push_back(v(6'b000001, 4, 0, 6'b110000, 0, 0));
        // burstcnt 0 becomes a single beat
        tbl.push_back(v(6'b100000, 0, 0, 6'b110000, 0, 0));
        tbl.push_back(v(6'b100000, 0, 0, 6'b010010, 1, ADDR_A));
        tbl.push_back(v(6'b000001, 0, 0, 6'b111000, 0, 0));
        tbl.push_back(v(6'b000001, 0, 0, 6'b110000, 0, 0));
        // B writes 3 beats, controller busy for 2 cycles on the 2nd beat, plus a gap
        tbl.push_back(v(6'b000100, 0, 3, 6'b110000, 0, 0));
        tbl.push_back(v(6'b000100, 0, 3, 6'b100001, 3, ADDR_B));
        tbl.push_back(v(6'b000110, 0, 3, 6'b110001, 0, 0));
        tbl.push_back(v(6'b000110, 0, 3, 6'b110001, 0, 0));
        tbl.push_back(v(6'b000100, 0, 3, 6'b100001, 0, 0));
        tbl.push_back(v(6'b000000, 0, 3, 6'b100000, 0, 0));
        tbl.push_back(v(6'b000100, 0, 3, 6'b100001, 0, 0));
        tbl.push_back(v(6'b000000, 0, 3, 6'b110000, 0, 0));
        // Round-robin: A, B, A, B with 2-beat reads
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(6'b101000, 2, 2, 6'b110000, 0, 0));
            tbl.push_back(v(6'b101000, 2, 2, 6'b010010, 2, ADDR_A));
            tbl.push_back(v(6'b001001, 2, 2, 6'b111000, 0, 0));
            tbl.push_back(v(6'b001001, 2, 2, 6'b111000, 0, 0));
            tbl.push_back(v(6'b101000, 2, 2, 6'b110000, 0, 0));
            tbl.push_back(v(6'b101000, 2, 2, 6'b100010, 2, ADDR_B));
            tbl.push_back(v(6'b100001, 2, 2, 6'b110100, 0, 0));
            tbl.push_back(v(6'b100001, 2, 2, 6'b110100, 0, 0));
        end
        // A abandons its read under busy; pending B write then granted
        tbl.push_back(v(6'b100100, 2, 1, 6'b110000, 0, 0));
        tbl.push_back(v(6'b100110, 2, 1, 6'b110010, 0, 0));
        tbl.push_back(v(6'b000110, 2, 1, 6'b110000, 0, 0));
        tbl.push_back(v(6'b000100, 2, 1, 6'b110000, 0, 0));
        tbl.push_back(v(6'b000100, 2, 1, 6'b100001, 1, ADDR_B));
        tbl.push_back(v(6'b000000, 2, 1, 6'b110000, 0, 0));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 6'b110000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            {a_rd, a_we, b_rd, b_we, ddram_busy, ddram_dout_ready} = tbl[i].in;
            a_burstcnt = tbl[i].a_bc;
            b_burstcnt = tbl[i].b_bc;
            ddram_dout = {$urandom, $urandom};
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].ex);
            chk($sformatf("vec%0d.dout", i), dout, ddram_dout);
            if (tbl[i].e_bc != 8'd0)
                chk($sformatf("vec%0d.ddram_burstcnt", i), {56'd0, ddram_burstcnt}, {56'd0, tbl[i].e_bc});
            if (tbl[i].e_addr != '0) begin
                chk($sformatf("vec%0d.ddram_addr", i), {35'd0, ddram_addr}, {35'd0, tbl[i].e_addr});
                chk($sformatf("vec%0d.ddram_din", i), ddram_din,
                    (tbl[i].e_addr == ADDR_A) ? DIN_A : DIN_B);
                chk($sformatf("vec%0d.ddram_be", i), {56'd0, ddram_be},
                    (tbl[i].e_addr == ADDR_A) ? 64'h0F : 64'hF0);
            end
        end

        // Reset in the middle of an 8-beat read, then stray beats
        @(negedge clk);
        {a_rd, a_we, b_rd, b_we, ddram_busy, ddram_dout_ready} = 6'b100000;
        a_burstcnt = 8'd8;
        @(negedge clk);
        @(negedge clk);
        a_rd = 1'b0;
        ddram_dout_ready = 1'b1;
        #1 chk("midrd.beat1", {63'd0, a_dout_ready}, 64'd1);
        @(negedge clk);
        #1 chk("midrd.beat2", {63'd0, a_dout_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs("midrd.in_reset", 6'b110000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check_outs($sformatf("stray%0d", k), 6'b110000);
        end
        ddram_dout_ready = 1'b0;

        // Fixed priority: A wins three consecutive ties
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            f_a_rd = 1'b1; f_b_rd = 1'b1; f_busy = 1'b0; f_dr = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("fp%0d.a_busy", k), {63'd0, f_a_busy}, 64'd0);
            chk($sformatf("fp%0d.b_busy", k), {63'd0, f_b_busy}, 64'd1);
            chk($sformatf("fp%0d.ddram_rd", k), {63'd0, f_rd}, 64'd1);
            @(negedge clk);
            f_a_rd = 1'b0; f_dr = 1'b1;
            #1 chk($sformatf("fp%0d.a_dr", k), {63'd0, f_a_dr}, 64'd1);
            @(negedge clk);
            #1 chk($sformatf("fp%0d.b_dr", k), {63'd0, f_b_dr}, 64'd0);
            f_a_rd = 1'b1;
        end
        f_a_rd = 1'b0; f_b_rd = 1'b0; f_dr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
